// File: rtl/aes_rcon_gen.sv
// AES key-expansion round-constant generator: emits the Rcon sequence one value per
// `next`, forward (01,02,04,...) or reverse (last constant down to 01), for 128/192/256-bit keys.
module aes_rcon_gen #(
    parameter logic [7:0] POLY  = 8'h1b,
    parameter int         CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             next,
    input  logic             dir,
    input  logic [1:0]       keylen,
    output logic [7:0]       rcon,
    output logic             rcon_valid,
    output logic [CNT_W-1:0] idx,
    output logic             last,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LEN_128 = CNT_W'(10);
    localparam logic [CNT_W-1:0] LEN_192 = CNT_W'(8);
    localparam logic [CNT_W-1:0] LEN_256 = CNT_W'(7);

    function automatic logic [7:0] xtime(input logic [7:0] r);
        xtime = {r[6:0], 1'b0} ^ (r[7] ? POLY : 8'h00);
    endfunction

    // Exact inverse of xtime; relies on POLY[0] being 1 so the dropped bit is recoverable.
    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        inv_xtime = {1'b0, r[7:1]} ^ (r[0] ? {1'b1, POLY[7:1]} : 8'h00);
    endfunction

    function automatic logic [7:0] start_rev(input logic [CNT_W-1:0] len);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < (1 << CNT_W); i++) begin
            if (i < int'(len)) begin
                v = xtime(v);
            end else begin
                v = v;
            end
        end
        start_rev = v;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [7:0]       rcon_r;
    logic [CNT_W-1:0] idx_r;
    logic             dir_r;
    logic [CNT_W-1:0] len_r;
    logic             done_r;
    logic [CNT_W-1:0] len_dec_s;
    logic             last_s;
    logic             valid_s;
    logic             accept_s;

    // Decode the requested key length into a sequence length.
    always_comb begin
        len_dec_s = LEN_128;
        case (keylen)
            2'd0:    len_dec_s = LEN_128;
            2'd1:    len_dec_s = LEN_256;
            2'd2:    len_dec_s = LEN_192;
            default: len_dec_s = LEN_128;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; init takes priority over next in every state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (init) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (init) begin
                    next_state_s = RUN;
                end else if (next && last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Status decoded from registered state only.
    always_comb begin
        valid_s  = 1'b0;
        last_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            RUN: begin
                valid_s  = 1'b1;
                last_s   = (idx_r == (len_r - CNT_W'(1)));
                accept_s = next && !init;
            end
            default: begin
                valid_s  = 1'b0;
                last_s   = 1'b0;
                accept_s = 1'b0;
            end
        endcase
    end

    // Constant, index and latched configuration; values hold after the final step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcon_r <= 8'h00;
            idx_r  <= '0;
            dir_r  <= 1'b0;
            len_r  <= LEN_128;
            done_r <= 1'b0;
        end else begin
            done_r <= accept_s && last_s;
            if (init) begin
                rcon_r <= dir ? start_rev(len_dec_s) : 8'h01;
                idx_r  <= '0;
                dir_r  <= dir;
                len_r  <= len_dec_s;
            end else if (accept_s && !last_s) begin
                rcon_r <= dir_r ? inv_xtime(rcon_r) : xtime(rcon_r);
                idx_r  <= idx_r + CNT_W'(1);
            end
        end
    end

    assign rcon       = rcon_r;
    assign idx        = idx_r;
    assign rcon_valid = valid_s;
    assign last       = last_s;
    assign done       = done_r;

endmodule

// File: tb/tb_aes_rcon_gen.sv
// Directed self-checking bench for aes_rcon_gen: default-POLY instance plus a POLY=8'h1d instance.
module tb_aes_rcon_gen;

    logic       clk;
    logic       reset;
    logic       init;
    logic       next;
    logic       dir;
    logic [1:0] keylen;

    logic [7:0] rcon;
    logic       rcon_valid;
    logic [3:0] idx;
    logic       last;
    logic       done;

    logic [7:0] rcon2;
    logic       rcon_valid2;
    logic [3:0] idx2;
    logic       last2;
    logic       done2;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd1b [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [7:0] fwd1d [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1d, 8'h3a};

    aes_rcon_gen #(.POLY(8'h1b), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .init(init), .next(next), .dir(dir), .keylen(keylen),
        .rcon(rcon), .rcon_valid(rcon_valid), .idx(idx), .last(last), .done(done)
    );

    aes_rcon_gen #(.POLY(8'h1d), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .init(init), .next(next), .dir(dir), .keylen(keylen),
        .rcon(rcon2), .rcon_valid(rcon_valid2), .idx(idx2), .last(last2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; next = 1'b0; dir = 1'b0; keylen = 2'd0;
        tick();
        tick();
        checks++;
        if ({rcon, idx, rcon_valid, last, done} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rcon=%h idx=%0d v=%b l=%b d=%b want 00 0 0 0 0",
                     rcon, idx, rcon_valid, last, done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fwd128();
        dir = 1'b0; keylen = 2'd0; init = 1'b1;
        tick();
        init = 1'b0; next = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rcon, idx, rcon_valid, last, done} !== {fwd1b[i], 4'(i), 1'b1, (i == 9), 1'b0}) begin
                errors++;
                $display("FAIL fwd128[%0d] got rcon=%h idx=%0d v=%b l=%b d=%b want %h %0d 1 %b 0",
                         i, rcon, idx, rcon_valid, last, done, fwd1b[i], i, (i == 9));
            end
            tick();
        end
        next = 1'b0;
        checks++;
        if ({done, rcon_valid, rcon, idx, last} !== {1'b1, 1'b0, 8'h36, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL fwd128_done got d=%b v=%b rcon=%h idx=%0d l=%b want 1 0 36 9 0",
                     done, rcon_valid, rcon, idx, last);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle got %b want 0", done);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] kl_tab [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        int         len_tab [4] = '{10, 7, 8, 10};
        for (int c = 0; c < 4; c++) begin
            dir = 1'b1; keylen = kl_tab[c]; init = 1'b1;
            tick();
            init = 1'b0; next = 1'b1;
            for (int i = 0; i < len_tab[c]; i++) begin
                checks++;
                if ({rcon, idx, rcon_valid, last} !==
                    {fwd1b[len_tab[c] - 1 - i], 4'(i), 1'b1, (i == len_tab[c] - 1)}) begin
                    errors++;
                    $display("FAIL rev kl=%0d [%0d] got rcon=%h idx=%0d v=%b l=%b want %h %0d 1 %b",
                             kl_tab[c], i, rcon, idx, rcon_valid, last,
                             fwd1b[len_tab[c] - 1 - i], i, (i == len_tab[c] - 1));
                end
                tick();
            end
            next = 1'b0;
            checks++;
            if ({done, rcon_valid, rcon} !== {1'b1, 1'b0, 8'h01}) begin
                errors++;
                $display("FAIL rev_done kl=%0d got d=%b v=%b rcon=%h want 1 0 01",
                         kl_tab[c], done, rcon_valid, rcon);
            end
        end
        dir = 1'b0; keylen = 2'd0;
    endtask

    task automatic test_protocol();
        dir = 1'b0; keylen = 2'd0; init = 1'b1;
        tick();
        init = 1'b0;
        for (int k = 1; k < 4; k++) begin
            next = 1'b1;
            tick();
            next = 1'b0;
            checks++;
            if ({rcon, idx} !== {fwd1b[k], 4'(k)}) begin
                errors++;
                $display("FAIL gapped_step[%0d] got rcon=%h idx=%0d want %h %0d", k, rcon, idx, fwd1b[k], k);
            end
            tick();
            tick();
            checks++;
            if ({rcon, idx} !== {fwd1b[k], 4'(k)}) begin
                errors++;
                $display("FAIL gapped_hold[%0d] got rcon=%h idx=%0d want %h %0d", k, rcon, idx, fwd1b[k], k);
            end
        end
        dir = 1'b1; keylen = 2'd1;
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if ({rcon, idx, last} !== {8'h10, 4'd4, 1'b0}) begin
            errors++;
            $display("FAIL dir_toggle_ignored got rcon=%h idx=%0d l=%b want 10 4 0", rcon, idx, last);
        end
        dir = 1'b0; keylen = 2'd0;
        init = 1'b1; next = 1'b1;
        tick();
        init = 1'b0; next = 1'b0;
        checks++;
        if ({rcon, idx, rcon_valid, done} !== {8'h01, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL init_beats_next got rcon=%h idx=%0d v=%b d=%b want 01 0 1 0",
                     rcon, idx, rcon_valid, done);
        end
        next = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        next = 1'b0;
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if ({done, rcon_valid, rcon, idx} !== {1'b0, 1'b0, 8'h36, 4'd9}) begin
            errors++;
            $display("FAIL next_in_idle got d=%b v=%b rcon=%h idx=%0d want 0 0 36 9",
                     done, rcon_valid, rcon, idx);
        end
    endtask

    task automatic test_async_reset();
        dir = 1'b0; keylen = 2'd0; init = 1'b1;
        tick();
        init = 1'b0; next = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        next = 1'b0;
        checks++;
        if ({rcon, idx} !== {8'h20, 4'd5}) begin
            errors++;
            $display("FAIL pre_reset got rcon=%h idx=%0d want 20 5", rcon, idx);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rcon, idx, rcon_valid, last, done} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got rcon=%h idx=%0d v=%b l=%b d=%b want 00 0 0 0 0",
                     rcon, idx, rcon_valid, last, done);
        end
        tick();
        reset = 1'b0;
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if ({rcon, idx, rcon_valid, done} !== {8'h00, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL next_after_reset got rcon=%h idx=%0d v=%b d=%b want 00 0 0 0",
                     rcon, idx, rcon_valid, done);
        end
        init = 1'b1;
        tick();
        init = 1'b0; next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if ({rcon, idx, rcon_valid} !== {8'h02, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL restart_after_reset got rcon=%h idx=%0d v=%b want 02 1 1", rcon, idx, rcon_valid);
        end
    endtask

    task automatic test_poly1d();
        for (int d = 0; d < 2; d++) begin
            dir = (d == 1); keylen = 2'd0; init = 1'b1;
            tick();
            init = 1'b0; next = 1'b1;
            for (int i = 0; i < 10; i++) begin
                checks++;
                if ({rcon2, idx2, last2} !== {(d == 1) ? fwd1d[9 - i] : fwd1d[i], 4'(i), (i == 9)}) begin
                    errors++;
                    $display("FAIL poly1d dir=%0d [%0d] got rcon=%h idx=%0d l=%b want %h %0d %b",
                             d, i, rcon2, idx2, last2, (d == 1) ? fwd1d[9 - i] : fwd1d[i], i, (i == 9));
                end
                tick();
            end
            next = 1'b0;
            checks++;
            if ({done2, rcon_valid2} !== {1'b1, 1'b0}) begin
                errors++;
                $display("FAIL poly1d_done dir=%0d got d=%b v=%b want 1 0", d, done2, rcon_valid2);
            end
        end
        dir = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd128();
        test_reverse();
        test_protocol();
        test_async_reset();
        test_poly1d();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
